// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data block-memory port arbiter.
// Build option MEM_ARB_FAIRNESS_EN enables the fetch starvation guard.
package mem_arb_pkg;

    typedef enum logic {
        OWNER_I,
        OWNER_D
    } owner_t;

    localparam int MEM_ADDR_W = 10;
    localparam int MEM_DATA_W = 32;

endpackage

// File: rtl/mem_arb_prio.sv
// Per-cycle grant logic: data over fetch, with an optional starvation guard
// for fetch when MEM_ARB_FAIRNESS_EN is defined.
module mem_arb_prio
`ifdef MEM_ARB_FAIRNESS_EN
#(
    parameter int STARVE_LIMIT = 4
)
`endif
(
`ifdef MEM_ARB_FAIRNESS_EN
    input  logic clk,
`endif
    input  logic rst,
    input  logic i_req,
    input  logic d_req,
    output logic i_gnt,
    output logic d_gnt
);

`ifdef MEM_ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_cnt_q;
    logic [CNT_W-1:0] starve_cnt_d;
    logic             starved;

    assign starved = (starve_cnt_q == LIMIT);

    always_comb begin
        d_gnt = ~rst & d_req & ~(i_req & starved);
        i_gnt = ~rst & i_req & ~d_gnt;
    end

    // Counts data wins while fetch waits; saturates at the limit.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (rst || !i_req || i_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt && !starved) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    always_comb begin
        d_gnt = ~rst & d_req;
        i_gnt = ~rst & i_req & ~d_req;
    end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a 1-cycle-latency single-port block memory between fetch and load/store.
// Build option MEM_ARB_FAIRNESS_EN bounds how long data can starve fetch.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_REQ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic              I_GNT,
    output logic              I_RVALID,
    output logic [DATA_W-1:0] I_RDATA,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_GNT,
    output logic              D_RVALID,
    output logic [DATA_W-1:0] D_RDATA,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic              MEM_WRITE_ENABLE,
    output logic [DATA_W-1:0] MEM_WRITE_DATA,
    input  logic [DATA_W-1:0] MEM_READ_DATA
);

    logic   i_gnt;
    logic   d_gnt;
    logic   valid_q;
    logic   valid_d;
    owner_t owner_q;
    owner_t owner_d;

`ifdef MEM_ARB_FAIRNESS_EN
    mem_arb_prio #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_prio (
        .clk  (CLK),
        .rst  (RST),
        .i_req(I_REQ),
        .d_req(D_REQ),
        .i_gnt(i_gnt),
        .d_gnt(d_gnt)
    );
`else
    mem_arb_prio u_prio (
        .rst  (RST),
        .i_req(I_REQ),
        .d_req(D_REQ),
        .i_gnt(i_gnt),
        .d_gnt(d_gnt)
    );
`endif

    assign I_GNT = i_gnt;
    assign D_GNT = d_gnt;

    always_comb begin
        MEM_ADDRESS      = '0;
        MEM_WRITE_ENABLE = 1'b0;
        MEM_WRITE_DATA   = '0;
        if (d_gnt) begin
            MEM_ADDRESS      = D_ADDR;
            MEM_WRITE_ENABLE = D_WE;
            MEM_WRITE_DATA   = D_WDATA;
        end else if (i_gnt) begin
            MEM_ADDRESS      = I_ADDR;
        end
    end

    always_comb begin
        valid_d = ~RST & (i_gnt | d_gnt);
        owner_d = d_gnt ? OWNER_D : OWNER_I;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= 1'b0;
            owner_q <= OWNER_I;
        end else begin
            valid_q <= valid_d;
            owner_q <= owner_d;
        end
    end

    // Reset in the response cycle drops the response (a write already stands).
    always_comb begin
        I_RVALID = valid_q & ~RST & (owner_q == OWNER_I);
        D_RVALID = valid_q & ~RST & (owner_q == OWNER_D);
        I_RDATA  = I_RVALID ? MEM_READ_DATA : '0;
        D_RDATA  = D_RVALID ? MEM_READ_DATA : '0;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency block memory between the instruction-fetch port and the load/store port of the core.
- Arbitrates per cycle, drives the memory's address/write-enable/write-data, and routes the registered read data back to whichever requester owns the in-flight access.
- Sits between the fetch/MEM pipeline stages and the block memory instance.

Parameters:
- ADDR_W, 10, word address width (memory depth 2**ADDR_W).
- DATA_W, 32, data word width.
- STARVE_LIMIT, 4, consecutive data grants tolerated while fetch waits (used only with the optional feature).

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous, active-high reset.
- I_REQ  in  1  fetch request valid.
- I_ADDR  in  ADDR_W  fetch word address.
- I_GNT  out  1  fetch request accepted this cycle.
- I_RVALID  out  1  fetch read data valid.
- I_RDATA  out  DATA_W  fetch read data.
- D_REQ  in  1  data request valid.
- D_WE  in  1  data request is a store.
- D_ADDR  in  ADDR_W  data word address.
- D_WDATA  in  DATA_W  store data.
- D_GNT  out  1  data request accepted this cycle.
- D_RVALID  out  1  data response valid (load data or store ack).
- D_RDATA  out  DATA_W  load data (pre-write contents on store).
- MEM_ADDRESS  out  ADDR_W  to memory.
- MEM_WRITE_ENABLE  out  1  to memory.
- MEM_WRITE_DATA  out  DATA_W  to memory.
- MEM_READ_DATA  in  DATA_W  from memory, registered inside the memory.

Behaviour:
- Clock CLK; reset RST is synchronous and active-high. All state updates on posedge CLK.
- Handshake:
  - Requester holds REQ and its address/data stable until GNT.
  - GNT is combinational from REQ and arbitration state; at most one GNT per cycle.
- Memory drive: MEM_* are driven combinationally from the granted request.
  - MEM_WRITE_ENABLE = D_GNT & D_WE.
  - With no grant: MEM_WRITE_ENABLE=0, MEM_ADDRESS=0, MEM_WRITE_DATA=0.
- Latency: a request granted in cycle N gets its RVALID in cycle N+1, with RDATA = MEM_READ_DATA.
  - One-deep owner register {valid, owner} records the cycle-N grant.
  - Fully pipelined: a new grant is allowed every cycle, including the cycle a response returns.
- Stores: D_RVALID pulses at N+1 as the write ack; D_RDATA carries the old word (memory is read-before-write).
- No response backpressure: requesters must sink RVALID.
- RDATA of the non-owning port is 0. RVALID is a single-cycle pulse.
- Arbitration, base rule: fixed priority, data > fetch. With both requesting, D_GNT=1 and I_GNT=0.
- Reset: owner.valid=0, starve counter=0, I_RVALID=D_RVALID=0, RDATA outputs=0.
  - RST asserted in the cycle after a grant suppresses that response; the memory write, if already issued, stands.
  - GNT outputs are forced 0 while RST=1.
- Address is a word index; no wrap or range checks. ADDR_W bits index the full memory.

Optional Feature:
- Macro MEM_ARB_FAIRNESS_EN.
- Defined:
  - A counter starve_cnt (width clog2(STARVE_LIMIT+1)) increments on each cycle where I_REQ=1 and D_GNT=1.
  - It resets to 0 when I_GNT=1, when I_REQ=0, or on RST.
  - When starve_cnt == STARVE_LIMIT and both request, fetch wins that cycle.
  - starve_cnt saturates at STARVE_LIMIT.
- Not defined: counter absent; pure data > fetch priority. Fetch may starve indefinitely.

Decomposition:
- Shared package mem_arb_pkg:
  - typedef enum logic {OWNER_I, OWNER_D} owner_t.
  - Localparams MEM_ADDR_W=10, MEM_DATA_W=32.
- One natural sub-module: mem_arb_prio, the combinational grant logic plus the optional starvation counter. The top level holds the owner register and the response mux.

Test Plan:
- Fetch only: I_REQ=1, I_ADDR=0x005, memory[5]=0xDEADBEEF -> I_GNT=1 in the same cycle; next cycle I_RVALID=1, I_RDATA=0xDEADBEEF, D_RVALID=0.
- Store then load, same address: D_WE=1, D_ADDR=0x010, D_WDATA=0x12345678 (old value 0x0), then load of 0x010 -> first D_RVALID with D_RDATA=0x0; second D_RVALID with D_RDATA=0x12345678; back-to-back grants, no bubble.
- Contention: I_REQ=D_REQ=1 for one cycle, then only I_REQ -> cycle 0 D_GNT; cycle 1 I_GNT, D_RVALID; cycle 2 I_RVALID; fetch address held stable throughout.
- Starvation (MEM_ARB_FAIRNESS_EN, STARVE_LIMIT=4): both requesting continuously -> grant pattern D,D,D,D,I repeating. Without the macro: D every cycle, I_GNT never asserts.
- Reset mid-operation: grant a load in cycle N, assert RST in cycle N+1 -> I_RVALID/D_RVALID stay 0 and GNTs are 0 during RST. After release, a fresh request completes with 1-cycle latency.
- Stall-free streaming: fetch addresses 0..15 requested continuously, no data requests -> 16 consecutive I_GNT, then 16 consecutive I_RVALID offset by one cycle, data in address order.
